// File: rtl/div_control_unit_pkg.sv
// Shared definitions for the restoring divider: default width and the one-hot controller encoding.
package div_control_unit_pkg;

  localparam int DIV_WIDTH = 8;

  localparam int IDX_IDLE  = 0;
  localparam int IDX_LOAD  = 1;
  localparam int IDX_SHIFT = 2;
  localparam int IDX_SUB   = 3;
  localparam int IDX_DONE  = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LOAD  = 5'b00010,
    S_SHIFT = 5'b00100,
    S_SUB   = 5'b01000,
    S_DONE  = 5'b10000
  } div_state_e;

endpackage

// File: rtl/div_control_unit_if.sv
// Request/result bundle between the ALU (master) and the divider (slave).
interface div_control_unit_if
  import div_control_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_control_unit_datapath.sv
// Shift/subtract datapath: partial remainder A, quotient/dividend Q, divisor M and iteration counter.
module div_control_unit_datapath
  import div_control_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             sub_commit_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             count_zero_o,
  output logic             div_zero_o,
  output logic             borrow_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] a_sub_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   diff;

  // The extra top bit of the difference is the borrow that decides subtract vs restore.
  assign diff         = {1'b0, a_q} - {1'b0, m_q};
  assign borrow_o     = diff[WIDTH];
  assign a_sub_o      = borrow_o ? a_q : diff[WIDTH-1:0];
  assign count_zero_o = (cnt_q == '0);
  assign div_zero_o   = (m_q == '0);
  assign q_o          = q_q;

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = '0;
      q_d   = dividend_i;
      m_d   = divisor_i;
      cnt_d = CW'(WIDTH);
    end else if (shift_i) begin
      {a_d, q_d} = {a_q, q_q} << 1;
      cnt_d      = cnt_q - CW'(1);
    end else if (sub_commit_i) begin
      a_d = a_sub_o;
      q_d = {q_q[WIDTH-1:1], ~borrow_o};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_control_unit.sv
// Multi-cycle restoring divider: one-hot controller plus result registers around the shift/subtract datapath.
module div_control_unit
  import div_control_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  div_control_unit_if.slave  bus
);

  div_state_e       state_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic             load, shift, sub_commit;
  logic             count_zero, div_zero, borrow;
  logic [WIDTH-1:0] dp_q, dp_a_sub;

  assign load       = state_q[IDX_IDLE] & bus.start;
  assign shift      = state_q[IDX_SHIFT];
  assign sub_commit = state_q[IDX_SUB];

  div_control_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .shift_i      (shift),
    .sub_commit_i (sub_commit),
    .dividend_i   (bus.dividend),
    .divisor_i    (bus.divisor),
    .count_zero_o (count_zero),
    .div_zero_o   (div_zero),
    .borrow_o     (borrow),
    .q_o          (dp_q),
    .a_sub_o      (dp_a_sub)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_q <= S_LOAD;
        S_LOAD: begin
          if (div_zero) begin
            state_q <= S_DONE;
            quot_q  <= '1;
            rem_q   <= dp_q;
            dbz_q   <= 1'b1;
          end else begin
            state_q <= S_SHIFT;
            dbz_q   <= 1'b0;
          end
        end
        S_SHIFT: state_q <= S_SUB;
        S_SUB: begin
          if (count_zero) begin
            state_q <= S_DONE;
            quot_q  <= {dp_q[WIDTH-1:1], ~borrow};
            rem_q   <= dp_a_sub;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = state_q[IDX_LOAD] | state_q[IDX_SHIFT] | state_q[IDX_SUB];
  assign bus.done        = state_q[IDX_DONE];
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_control_unit.sv
// Directed and swept checks of the restoring divider: latency, results, divide-by-zero, ignored starts, reset abort.
module tb_div_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  div_control_unit_if #(.WIDTH(8)) bus ();

  div_control_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Launches one op with a single-cycle start and scrambles the operands right after acceptance.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_n);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'hA5;
    bus.divisor  = 8'h5A;
    lat    = -1;
    busy_n = bus.busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_basic;
    int lat, busy_n;
    run_op(8'd100, 8'd7, lat, busy_n);
    n_checks++;
    if (lat !== 17) $display("FAIL basic_latency: got %0d, want 17", lat); else n_pass++;
    n_checks++;
    if (busy_n !== 17) $display("FAIL basic_busy_cycles: got %0d, want 17", busy_n); else n_pass++;
    n_checks++;
    if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0)
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want 14 2 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b, want 0", bus.busy); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b, want 0", bus.done); else n_pass++;
    n_checks++;
    if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2)
      $display("FAIL basic_hold: got q=%0d r=%0d, want 14 2", bus.quotient, bus.remainder);
    else n_pass++;
  endtask

  task automatic test_corners;
    logic [7:0] va[3] = '{8'd255, 8'd5, 8'd0};
    logic [7:0] vb[3] = '{8'd1, 8'd9, 8'd3};
    logic [7:0] eq[3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] er[3] = '{8'd0, 8'd5, 8'd0};
    int lat, busy_n;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, busy_n);
      n_checks++;
      if (lat !== 17 || bus.quotient !== eq[i] || bus.remainder !== er[i] || bus.div_by_zero !== 1'b0)
        $display("FAIL corner_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want 17 %0d %0d 0",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, eq[i], er[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero;
    int lat, busy_n;
    run_op(8'd42, 8'd0, lat, busy_n);
    n_checks++;
    if (lat !== 1) $display("FAIL dbz_latency: got %0d, want 1", lat); else n_pass++;
    n_checks++;
    if (bus.div_by_zero !== 1'b1 || bus.quotient !== 8'hFF || bus.remainder !== 8'd42)
      $display("FAIL dbz_result: got dbz=%b q=%h r=%0d, want 1 ff 42",
               bus.div_by_zero, bus.quotient, bus.remainder);
    else n_pass++;
    run_op(8'd50, 8'd6, lat, busy_n);
    n_checks++;
    if (bus.div_by_zero !== 1'b0 || bus.quotient !== 8'd8 || bus.remainder !== 8'd2 || lat !== 17)
      $display("FAIL dbz_cleared: got dbz=%b q=%0d r=%0d lat=%0d, want 0 8 2 17",
               bus.div_by_zero, bus.quotient, bus.remainder, lat);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int lat = -1;
    @(negedge clk);
    bus.dividend = 8'd200;
    bus.divisor  = 8'd9;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd3;
        bus.divisor  = 8'd1;
      end
      if (k == 5) begin
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.quotient !== 8'd8 || bus.remainder !== 8'd2)
          $display("FAIL ignore_mid_op: got busy=%b q=%0d r=%0d, want 1 8 2",
                   bus.busy, bus.quotient, bus.remainder);
        else n_pass++;
      end
      if (bus.done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    n_checks++;
    if (dones !== 1 || lat !== 17)
      $display("FAIL ignore_done_once: got dones=%0d lat=%0d, want 1 17", dones, lat);
    else n_pass++;
    n_checks++;
    if (bus.quotient !== 8'd22 || bus.remainder !== 8'd2)
      $display("FAIL ignore_result: got q=%0d r=%0d, want 22 2", bus.quotient, bus.remainder);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat, busy_n;
    @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0)
      $display("FAIL reset_mid_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", dones); else n_pass++;
    run_op(8'd77, 8'd5, lat, busy_n);
    n_checks++;
    if (lat !== 17 || bus.quotient !== 8'd15 || bus.remainder !== 8'd2)
      $display("FAIL reset_mid_recover: got lat=%0d q=%0d r=%0d, want 17 15 2",
               lat, bus.quotient, bus.remainder);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] cur_a, cur_b, nxt_a, nxt_b, eq, er;
    int last_done = 0;
    int t;
    int exp_gap;
    bit first = 1'b1;
    bit exp_dbz;
    cur_a = 8'($urandom_range(0, 255));
    cur_b = 8'($urandom_range(1, 255));
    @(negedge clk);
    bus.dividend = cur_a;
    bus.divisor  = cur_b;
    bus.start    = 1'b1;
    @(posedge clk);
    for (int op = 0; op < 2000; op++) begin
      nxt_a = 8'($urandom_range(0, 255));
      nxt_b = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      @(negedge clk);
      bus.dividend = nxt_a;
      bus.divisor  = nxt_b;
      t = 0;
      while (!bus.done && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!bus.done) begin
        n_checks++;
        $display("FAIL sweep_timeout: op %0d got no done within 60 cycles, want done", op);
        break;
      end
      exp_dbz = (cur_b == 8'd0);
      eq = exp_dbz ? 8'hFF : 8'(int'(cur_a) / int'(cur_b));
      er = exp_dbz ? cur_a : 8'(int'(cur_a) % int'(cur_b));
      n_checks++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== exp_dbz)
        $display("FAIL sweep_result: op %0d %0d/%0d got q=%0d r=%0d dbz=%b, want %0d %0d %b",
                 op, cur_a, cur_b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, exp_dbz);
      else n_pass++;
      if (!first) begin
        exp_gap = exp_dbz ? 3 : 19;
        n_checks++;
        if (cyc - last_done !== exp_gap)
          $display("FAIL sweep_spacing: op %0d got %0d, want %0d", op, cyc - last_done, exp_gap);
        else n_pass++;
      end
      last_done = cyc;
      first = 1'b0;
      cur_a = nxt_a;
      cur_b = nxt_b;
      @(posedge clk);
      @(posedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
